// File: rtl/mult_limb_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_limb_seq_if
//  Description : Request/response bundle for the sequential limb multiplier.
//                The master issues start/abort with operands; the slave
//                reports busy/done/overrun and the held 2W-bit product.
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_limb_seq_if #(
  parameter int W = 256
);
  logic           start_i;
  logic           abort_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           busy_o;
  logic           done_o;
  logic [2*W-1:0] p_o;
  logic           ovr_o;

  modport master (
    output start_i, abort_i, a_i, b_i,
    input  busy_o, done_o, p_o, ovr_o
  );

  modport slave (
    input  start_i, abort_i, a_i, b_i,
    output busy_o, done_o, p_o, ovr_o
  );
endinterface
`default_nettype wire

// File: rtl/mult_limb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_limb_seq
//  Description : Sequential W x W unsigned multiplier. Operands are split
//                into W/LW limbs; every limb pair is pushed, one per cycle,
//                through a single LW x LW multiplier with MPPX register
//                stages, and the shifted partial products are summed into a
//                2W-bit accumulator. W must be a multiple of LW, MPPX >= 1.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_limb_seq #(
  parameter int W    = 256,
  parameter int LW   = 64,
  parameter int MPPX = 5
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  mult_limb_seq_if.slave   bus
);

  localparam int c_NL    = W / LW;
  localparam int c_NSTEP = c_NL * c_NL;
  localparam int c_NDONE = c_NSTEP + MPPX;
  localparam int c_SW    = $clog2(c_NDONE + 1);
  localparam int c_IW    = (c_NL > 1) ? $clog2(c_NL) : 1;
  // Holds the largest limb-shift index i+j = 2*(NL-1).
  localparam int c_SHW   = (c_NL > 1) ? $clog2(2 * c_NL) : 1;

  logic                r_busy;
  logic                r_done;
  logic [c_SW-1:0]     r_step;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [2*W-1:0]      r_acc;
  logic [2*W-1:0]      r_p;

  logic [MPPX-1:0]     r_pv;
  logic [2*LW-1:0]     r_pp [MPPX];
  logic [c_SHW-1:0]    r_ps [MPPX];

  logic                w_issue;
  logic [c_IW-1:0]     w_i;
  logic [c_IW-1:0]     w_j;
  logic [LW-1:0]       w_la;
  logic [LW-1:0]       w_lb;
  logic [2*LW-1:0]     w_prod;
  logic [c_SHW-1:0]    w_sh;
  logic [2*W-1:0]      w_term;
  logic [2*W-1:0]      w_acc_next;

  // Select the limb pair for the current step; past the last pair issue zeros.
  always_comb begin
    w_issue = r_busy && (r_step < c_SW'(c_NSTEP));
    w_i     = '0;
    w_j     = '0;
    w_la    = '0;
    w_lb    = '0;
    if (w_issue) begin
      w_i  = c_IW'(r_step / c_SW'(c_NL));
      w_j  = c_IW'(r_step % c_SW'(c_NL));
      w_la = LW'(r_a >> (int'(w_i) * LW));
      w_lb = LW'(r_b >> (int'(w_j) * LW));
    end
    w_prod = (2*LW)'(w_la) * (2*LW)'(w_lb);
    w_sh   = c_SHW'(w_i) + c_SHW'(w_j);
  end

  // Align the product leaving the pipeline and add it to the running sum.
  always_comb begin
    w_term     = (2*W)'(r_pp[MPPX-1]) << (int'(r_ps[MPPX-1]) * LW);
    w_acc_next = r_acc + (r_pv[MPPX-1] ? w_term : '0);
  end

  // Multiplier pipeline: product, shift index and valid move together;
  // an abort drops every in-flight valid so nothing leaks into a later job.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_pv <= '0;
      for (int s = 0; s < MPPX; s++) begin
        r_pp[s] <= '0;
        r_ps[s] <= '0;
      end
    end else begin
      r_pp[0] <= w_prod;
      r_ps[0] <= w_sh;
      for (int s = 1; s < MPPX; s++) begin
        r_pp[s] <= r_pp[s-1];
        r_ps[s] <= r_ps[s-1];
      end
      if (bus.abort_i && r_busy) begin
        r_pv <= '0;
      end else begin
        r_pv[0] <= w_issue;
        for (int s = 1; s < MPPX; s++) begin
          r_pv[s] <= r_pv[s-1];
        end
      end
    end
  end

  // Control: accept, step counting, accumulation, completion and abort.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_step <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_p    <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (bus.start_i) begin
          r_a    <= bus.a_i;
          r_b    <= bus.b_i;
          r_acc  <= '0;
          r_step <= '0;
          r_busy <= 1'b1;
        end
      end else if (bus.abort_i) begin
        r_busy <= 1'b0;
        r_step <= '0;
      end else begin
        r_acc <= w_acc_next;
        if (r_step == c_SW'(c_NDONE - 1)) begin
          // Last partial product lands now: publish and go idle together.
          r_p    <= w_acc_next;
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_step <= c_SW'(c_NDONE);
        end else begin
          r_step <= r_step + c_SW'(1);
        end
      end
    end
  end

  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;
  assign bus.p_o    = r_p;
  // A rejected start is flagged in the very cycle it is presented.
  assign bus.ovr_o  = bus.start_i & r_busy & ~bus.abort_i;

endmodule
`default_nettype wire

// File: tb/tb_mult_limb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_limb_seq
//  Description : Self-checking bench for mult_limb_seq. Random and directed
//                operands are compared against a plain-arithmetic product;
//                latency, handshake, overrun, abort and reset are checked.
//                A second instance covers the single-limb configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_limb_seq;

  localparam int LAT   = 21;  // 4*4 limb products + 5 pipeline stages
  localparam int LAT64 = 4;   // 1 limb product + 3 pipeline stages

  logic clk;
  logic arst_n;
  int   n_vec;
  int   n_err;

  mult_limb_seq_if #(.W(256)) bus ();
  mult_limb_seq_if #(.W(64))  bus64 ();

  mult_limb_seq #(.W(256), .LW(64), .MPPX(5)) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus.slave)
  );

  mult_limb_seq #(.W(64), .LW(64), .MPPX(3)) dut64 (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mul_ref(input logic [255:0] a, input logic [255:0] b);
    mul_ref = {256'b0, a} * {256'b0, b};
  endfunction

  // Operands built from zero, all-ones and random limbs to stress carries.
  function automatic logic [255:0] rnd_op();
    logic [255:0] r;
    logic [63:0]  limb;
    r = '0;
    for (int n = 0; n < 4; n++) begin
      case ($urandom_range(0, 3))
        0:       limb = '0;
        1:       limb = '1;
        default: limb = {$urandom, $urandom};
      endcase
      r[n*64 +: 64] = limb;
    end
    return r;
  endfunction

  // One operation on the 256-bit instance. ovr_at/abort_at < 0 disable those
  // events; chain issues the next start in the done cycle; started means the
  // start request is already on the bus.
  task automatic op(input logic [255:0] a, input logic [255:0] b,
                    input int ovr_at, input int abort_at, input bit chain,
                    input logic [255:0] na, input logic [255:0] nb, input bit started);
    logic [511:0] p_prev;
    int done_c;
    p_prev = bus.p_o;
    if (!started) begin
      bus.a_i     = a;
      bus.b_i     = b;
      bus.start_i = 1'b1;
      bus.abort_i = 1'($urandom_range(0, 1));  // abort while idle must not block the start
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    done_c = -1;
    for (int c = 0; c <= LAT + 3; c++) begin
      if (c == ovr_at) begin
        bus.start_i = 1'b1;
        bus.a_i     = rnd_op();
        bus.b_i     = rnd_op();
      end
      if (c == abort_at) bus.abort_i = 1'b1;
      @(negedge clk);
      if (c == 0) chk("busy_after_accept", bus.busy_o, 1);
      if (c == 5) chk("p_held_during_op", bus.p_o, p_prev);
      if (c == ovr_at) chk("ovr_on_busy_start", bus.ovr_o, (c == abort_at) ? 0 : 1);
      if (ovr_at >= 0 && c == ovr_at + 1) chk("ovr_one_cycle", bus.ovr_o, 0);
      if (abort_at < 0 && c == LAT - 1) chk("busy_last_step", bus.busy_o, 1);
      if (abort_at >= 0 && c == abort_at + 1) begin
        chk("busy_after_abort", bus.busy_o, 0);
        chk("p_after_abort", bus.p_o, p_prev);
      end
      if (abort_at < 0 && !chain && c == LAT + 1) chk("done_one_cycle", bus.done_o, 0);
      if (bus.done_o && done_c < 0) begin
        done_c = c;
        chk("product", bus.p_o, mul_ref(a, b));
        chk("busy_low_in_done", bus.busy_o, 0);
        if (chain) begin
          bus.a_i     = na;
          bus.b_i     = nb;
          bus.start_i = 1'b1;
          #1;
          chk("ovr_b2b", bus.ovr_o, 0);
          break;
        end
      end
      if (abort_at >= 0 && c == abort_at + 2) break;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
    end
    chk("done_cycle", done_c, (abort_at >= 0) ? -1 : LAT);
  endtask

  // One operation on the single-limb instance.
  task automatic op64(input logic [63:0] a, input logic [63:0] b);
    int done_c;
    bus64.a_i     = a;
    bus64.b_i     = b;
    bus64.start_i = 1'b1;
    @(posedge clk); #1;
    bus64.start_i = 1'b0;
    done_c = -1;
    for (int c = 0; c <= LAT64 + 3; c++) begin
      @(negedge clk);
      if (bus64.done_o && done_c < 0) begin
        done_c = c;
        chk("product64", bus64.p_o, {384'b0, {64'b0, a} * {64'b0, b}});
      end
      @(posedge clk); #1;
    end
    chk("done_cycle64", done_c, LAT64);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] ones;
    logic [255:0] x;
    logic [255:0] y;
    logic [511:0] k;
    n_vec = 0;
    n_err = 0;
    ones  = '1;
    bus.start_i   = 1'b0;
    bus.abort_i   = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    bus64.start_i = 1'b0;
    bus64.abort_i = 1'b0;
    bus64.a_i     = '0;
    bus64.b_i     = '0;
    arst_n = 1'b0;

    #3;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_p", bus.p_o, 0);
    chk("rst_ovr", bus.ovr_o, 0);
    chk("rst_busy64", bus64.busy_o, 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    // All-ones operands: every limb product carries into its neighbour.
    op(ones, ones, -1, -1, 1'b0, '0, '0, 1'b0);
    k = '0 - (512'd1 << 257) + 512'd1;
    chk("p_allones_const", bus.p_o, k);

    // Cross-limb shifted accumulation.
    x = 256'd1 << 64;
    y = (256'd1 << 192) + 256'd3;
    op(x, y, -1, -1, 1'b0, '0, '0, 1'b0);
    k = (512'd1 << 256) + (512'd3 << 64);
    chk("p_shift_const", bus.p_o, k);

    // Start while busy is rejected and flagged.
    op(256'd1 << 255, 256'd3, 7, -1, 1'b0, '0, '0, 1'b0);
    chk("p_ovr_const", bus.p_o, 512'd3 << 255);

    // Abort mid-operation, then a small product shortly after.
    op(ones, ones, -1, 10, 1'b0, '0, '0, 1'b0);
    op(256'd5, 256'd7, -1, -1, 1'b0, '0, '0, 1'b0);
    chk("p_after_abort_const", bus.p_o, 512'd35);

    // Back-to-back: next start presented in the done cycle.
    x = rnd_op();
    y = rnd_op();
    op(rnd_op(), rnd_op(), -1, -1, 1'b1, x, y, 1'b0);
    op(x, y, -1, -1, 1'b0, '0, '0, 1'b1);

    // Abort and start together while busy: abort wins, no overrun.
    op(rnd_op(), rnd_op(), 9, 9, 1'b0, '0, '0, 1'b0);

    // Randomized operands, some with a rejected start mid-flight.
    for (int n = 0; n < 8; n++) begin
      op(rnd_op(), rnd_op(), ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 19)) : -1,
         -1, 1'b0, '0, '0, 1'b0);
    end

    // Asynchronous reset in the middle of an operation.
    bus.a_i     = rnd_op();
    bus.b_i     = rnd_op();
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_done", bus.done_o, 0);
    chk("midrst_p", bus.p_o, 0);
    chk("midrst_ovr", bus.ovr_o, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    op(rnd_op(), rnd_op(), -1, -1, 1'b0, '0, '0, 1'b0);

    // Single-limb configuration.
    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("p64_const", bus64.p_o, {384'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001});
    for (int n = 0; n < 3; n++) begin
      op64({$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
